// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back over a
// single shared memory port and drives PC, IR, register file, ALU, memory and SP strobes.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [1:0] mode,
  input  logic       cmp_gt,
  input  logic       cmp_lt,
  input  logic       cmp_eq,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       base_wb,
  output logic       alu_src_imm,
  output logic [2:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] addr_sel,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC      = 4'd2,
    S_ADDR      = 4'd3,
    S_MEM       = 4'd4,
    S_BRANCH    = 4'd5,
    S_CALL_PUSH = 4'd6,
    S_STK_WR    = 4'd7,
    S_STK_RD    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ANDI = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b000101;
  localparam logic [5:0] OP_SW   = 6'b000110;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_BLT  = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b001001;
  localparam logic [5:0] OP_BNE  = 6'b001010;
  localparam logic [5:0] OP_JMP  = 6'b001100;
  localparam logic [5:0] OP_CALL = 6'b001101;
  localparam logic [5:0] OP_RET  = 6'b001110;
  localparam logic [5:0] OP_PUSH = 6'b001111;
  localparam logic [5:0] OP_POP  = 6'b010000;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_CMP = 3'd3;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic               wait_state;
  logic               timeout;
  logic               taken;

  assign wait_state = state_q inside {S_FETCH, S_MEM, S_CALL_PUSH, S_STK_WR, S_STK_RD};
  assign timeout    = (MEM_TIMEOUT != 0) && !mem_ready &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign taken      = ((opcode == OP_BGT) && cmp_gt) || ((opcode == OP_BLT) && cmp_lt) ||
                      ((opcode == OP_BEQ) && cmp_eq) || ((opcode == OP_BNE) && !cmp_eq);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (wait_state && !mem_ready && (MEM_TIMEOUT != 0))
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (state_d == S_TRAP)
        illegal_op <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    base_wb     = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_AND;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 2'd0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;

    // NOTE: outputs are gated by reset_n so a reset mid-access drops the memory
    // request at once instead of presenting the FETCH read during reset.
    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI: state_d = S_EXEC;
            OP_LW, OP_SW:     state_d = mode[1] ? S_TRAP : S_ADDR;
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_JMP: begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
              state_d  = S_FETCH;
            end
            OP_CALL:          state_d = S_CALL_PUSH;
            OP_RET, OP_POP:   state_d = S_STK_RD;
            OP_PUSH:          state_d = S_STK_WR;
            default:          state_d = S_TRAP;
          endcase
        end
        S_EXEC: begin
          reg_write   = 1'b1;
          alu_src_imm = (opcode == OP_ANDI) || (opcode == OP_ADDI);
          case (opcode)
            OP_ADD, OP_ADDI: alu_op = ALU_ADD;
            OP_SUB:          alu_op = ALU_SUB;
            default:         alu_op = ALU_AND;
          endcase
          state_d = S_FETCH;
        end
        S_ADDR: begin
          alu_op      = ALU_ADD;
          alu_src_imm = 1'b1;
          state_d     = S_MEM;
        end
        S_MEM: begin
          addr_sel  = 2'd1;
          mem_write = (opcode == OP_SW);
          mem_read  = (opcode != OP_SW);
          if (mem_ready) begin
            if (opcode == OP_LW) begin
              reg_write = 1'b1;
              wb_sel    = 2'd1;
            end
            base_wb = (mode == 2'b01);
            state_d = S_FETCH;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_BRANCH: begin
          alu_op = ALU_CMP;
          if (taken) begin
            pc_write = 1'b1;
            pc_src   = 2'd1;
          end
          state_d = S_FETCH;
        end
        S_CALL_PUSH: begin
          mem_write = 1'b1;
          addr_sel  = 2'd2;
          if (mem_ready) begin
            sp_inc   = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_d  = S_FETCH;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_STK_WR: begin
          mem_write = 1'b1;
          addr_sel  = 2'd2;
          if (mem_ready) begin
            sp_inc  = 1'b1;
            state_d = S_FETCH;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_STK_RD: begin
          mem_read = 1'b1;
          addr_sel = 2'd3;
          if (mem_ready) begin
            sp_dec = 1'b1;
            if (opcode == OP_POP) begin
              reg_write = 1'b1;
              wb_sel    = 2'd1;
            end else begin
              pc_write = 1'b1;
              pc_src   = 2'd3;
            end
            state_d = S_FETCH;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_TRAP;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table of inputs and expected
// outputs, plus hand-written sequences for reset, mode traps and memory timeouts.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [1:0] mode;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic       mem_ready;
  logic       ir_write, pc_write, reg_write, base_wb, alu_src_imm;
  logic       mem_read, mem_write, sp_inc, sp_dec, illegal_op;
  logic [1:0] pc_src, wb_sel, addr_sel;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mode(mode),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .base_wb(base_wb),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .addr_sel(addr_sel), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC = 4'd2,
                         ST_ADDR = 4'd3, ST_MEM = 4'd4, ST_BRANCH = 4'd5,
                         ST_CPUSH = 4'd6, ST_STKWR = 4'd7, ST_STKRD = 4'd8,
                         ST_TRAP = 4'd9;

  localparam logic [5:0] OP_ADD = 6'b000001, OP_SUB = 6'b000010, OP_ANDI = 6'b000011,
                         OP_ADDI = 6'b000100, OP_LW = 6'b000101, OP_SW = 6'b000110,
                         OP_BGT = 6'b000111, OP_BLT = 6'b001000, OP_BEQ = 6'b001001,
                         OP_BNE = 6'b001010, OP_JMP = 6'b001100, OP_CALL = 6'b001101,
                         OP_RET = 6'b001110, OP_PUSH = 6'b001111, OP_POP = 6'b010000,
                         OP_BAD = 6'b111111;

  localparam logic [9:0] NONE = 10'd0,   IRW = 10'd1,   PCW = 10'd2,   RGW = 10'd4,
                         BWB = 10'd8,    IMM = 10'd16,  MRD = 10'd32,  MWR = 10'd64,
                         SPI = 10'd128,  SPD = 10'd256, ILL = 10'd512;

  typedef struct {
    string       name;
    logic [5:0]  opcode;
    logic [1:0]  mode;
    logic [2:0]  flags;    // {gt, lt, eq}
    logic        mem_ready;
    logic [22:0] expected;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // {state, ir_write, pc_write, pc_src, reg_write, wb_sel, base_wb, alu_src_imm,
  //  alu_op, mem_read, mem_write, addr_sel, sp_inc, sp_dec, illegal_op}
  logic [22:0] act;
  assign act = {state, ir_write, pc_write, pc_src, reg_write, wb_sel, base_wb,
                alu_src_imm, alu_op, mem_read, mem_write, addr_sel, sp_inc, sp_dec,
                illegal_op};

  function automatic logic [22:0] exp_of(input logic [3:0] st, input logic [9:0] s,
                                         input logic [1:0] psrc, input logic [1:0] wsel,
                                         input logic [2:0] aop, input logic [1:0] asel);
    return {st, s[0], s[1], psrc, s[2], wsel, s[3], s[4], aop, s[5], s[6], asel,
            s[7], s[8], s[9]};
  endfunction

  task automatic vec(input string name, input logic [5:0] op, input logic [1:0] md,
                     input logic [2:0] flg, input logic rdy, input logic [3:0] st,
                     input logic [9:0] strb, input logic [1:0] psrc, input logic [1:0] wsel,
                     input logic [2:0] aop, input logic [1:0] asel);
    vec_t v;
    v.name = name; v.opcode = op; v.mode = md; v.flags = flg; v.mem_ready = rdy;
    v.expected = exp_of(st, strb, psrc, wsel, aop, asel);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic ir_seen;

  initial begin
    // ALU instructions (ANDI/ADDI carry non-01 modes, which must be ignored)
    vec("fetch_wait", OP_ADD, 2'b00, 3'b000, 1'b0, ST_FETCH,  MRD,             2'd0, 2'd0, 3'd0, 2'd0);
    vec("add_fetch",  OP_ADD, 2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("add_decode", OP_ADD, 2'b00, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("add_exec",   OP_ADD, 2'b00, 3'b000, 1'b1, ST_EXEC,   RGW,             2'd0, 2'd0, 3'd1, 2'd0);
    vec("sub_fetch",  OP_SUB, 2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("sub_decode", OP_SUB, 2'b00, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("sub_exec",   OP_SUB, 2'b00, 3'b000, 1'b1, ST_EXEC,   RGW,             2'd0, 2'd0, 3'd2, 2'd0);
    vec("andi_fetch", OP_ANDI,2'b11, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("andi_dec",   OP_ANDI,2'b11, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("andi_exec",  OP_ANDI,2'b11, 3'b000, 1'b1, ST_EXEC,   RGW|IMM,         2'd0, 2'd0, 3'd0, 2'd0);
    vec("addi_fetch", OP_ADDI,2'b10, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("addi_dec",   OP_ADDI,2'b10, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("addi_exec",  OP_ADDI,2'b10, 3'b000, 1'b1, ST_EXEC,   RGW|IMM,         2'd0, 2'd0, 3'd1, 2'd0);
    // LW post-increment with three wait cycles in MEM
    vec("lw_fetch",   OP_LW,  2'b01, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("lw_decode",  OP_LW,  2'b01, 3'b000, 1'b0, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("lw_addr",    OP_LW,  2'b01, 3'b000, 1'b0, ST_ADDR,   IMM,             2'd0, 2'd0, 3'd1, 2'd0);
    vec("lw_wait1",   OP_LW,  2'b01, 3'b000, 1'b0, ST_MEM,    MRD,             2'd0, 2'd0, 3'd0, 2'd1);
    vec("lw_wait2",   OP_LW,  2'b01, 3'b000, 1'b0, ST_MEM,    MRD,             2'd0, 2'd0, 3'd0, 2'd1);
    vec("lw_wait3",   OP_LW,  2'b01, 3'b000, 1'b0, ST_MEM,    MRD,             2'd0, 2'd0, 3'd0, 2'd1);
    vec("lw_done",    OP_LW,  2'b01, 3'b000, 1'b1, ST_MEM,    MRD|RGW|BWB,     2'd0, 2'd1, 3'd0, 2'd1);
    // SW, no post-increment
    vec("sw_fetch",   OP_SW,  2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("sw_decode",  OP_SW,  2'b00, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("sw_addr",    OP_SW,  2'b00, 3'b000, 1'b1, ST_ADDR,   IMM,             2'd0, 2'd0, 3'd1, 2'd0);
    vec("sw_mem",     OP_SW,  2'b00, 3'b000, 1'b1, ST_MEM,    MWR,             2'd0, 2'd0, 3'd0, 2'd1);
    // Branches: BEQ taken, BNE not taken, BGT taken, BLT not taken
    vec("beq_fetch",  OP_BEQ, 2'b00, 3'b001, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("beq_decode", OP_BEQ, 2'b00, 3'b001, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("beq_taken",  OP_BEQ, 2'b00, 3'b001, 1'b1, ST_BRANCH, PCW,             2'd1, 2'd0, 3'd3, 2'd0);
    vec("bne_fetch",  OP_BNE, 2'b00, 3'b001, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("bne_decode", OP_BNE, 2'b00, 3'b001, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("bne_not",    OP_BNE, 2'b00, 3'b001, 1'b1, ST_BRANCH, NONE,            2'd0, 2'd0, 3'd3, 2'd0);
    vec("bgt_fetch",  OP_BGT, 2'b00, 3'b100, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("bgt_decode", OP_BGT, 2'b00, 3'b100, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("bgt_taken",  OP_BGT, 2'b00, 3'b100, 1'b1, ST_BRANCH, PCW,             2'd1, 2'd0, 3'd3, 2'd0);
    vec("blt_fetch",  OP_BLT, 2'b00, 3'b100, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("blt_decode", OP_BLT, 2'b00, 3'b100, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("blt_not",    OP_BLT, 2'b00, 3'b100, 1'b1, ST_BRANCH, NONE,            2'd0, 2'd0, 3'd3, 2'd0);
    // JMP resolves in DECODE
    vec("jmp_fetch",  OP_JMP, 2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("jmp_decode", OP_JMP, 2'b00, 3'b000, 1'b1, ST_DECODE, PCW,             2'd2, 2'd0, 3'd0, 2'd0);
    // CALL then RET
    vec("call_fetch", OP_CALL,2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("call_dec",   OP_CALL,2'b00, 3'b000, 1'b0, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("call_wait",  OP_CALL,2'b00, 3'b000, 1'b0, ST_CPUSH,  MWR,             2'd0, 2'd0, 3'd0, 2'd2);
    vec("call_push",  OP_CALL,2'b00, 3'b000, 1'b1, ST_CPUSH,  MWR|SPI|PCW,     2'd2, 2'd0, 3'd0, 2'd2);
    vec("ret_fetch",  OP_RET, 2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("ret_decode", OP_RET, 2'b00, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("ret_pop",    OP_RET, 2'b00, 3'b000, 1'b1, ST_STKRD,  MRD|SPD|PCW,     2'd3, 2'd0, 3'd0, 2'd3);
    // PUSH then POP
    vec("push_fetch", OP_PUSH,2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("push_dec",   OP_PUSH,2'b00, 3'b000, 1'b0, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("push_wait",  OP_PUSH,2'b00, 3'b000, 1'b0, ST_STKWR,  MWR,             2'd0, 2'd0, 3'd0, 2'd2);
    vec("push_done",  OP_PUSH,2'b00, 3'b000, 1'b1, ST_STKWR,  MWR|SPI,         2'd0, 2'd0, 3'd0, 2'd2);
    vec("pop_fetch",  OP_POP, 2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("pop_decode", OP_POP, 2'b00, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("pop_done",   OP_POP, 2'b00, 3'b000, 1'b1, ST_STKRD,  MRD|SPD|RGW,     2'd0, 2'd1, 3'd0, 2'd3);
    // Illegal opcode: TRAP is sticky even with a legal opcode and mem_ready high
    vec("bad_fetch",  OP_BAD, 2'b00, 3'b000, 1'b1, ST_FETCH,  IRW|PCW|MRD,     2'd0, 2'd0, 3'd0, 2'd0);
    vec("bad_decode", OP_BAD, 2'b00, 3'b000, 1'b1, ST_DECODE, NONE,            2'd0, 2'd0, 3'd0, 2'd0);
    vec("trap_enter", OP_BAD, 2'b00, 3'b000, 1'b1, ST_TRAP,   ILL,             2'd0, 2'd0, 3'd0, 2'd0);
    vec("trap_stay",  OP_ADD, 2'b00, 3'b111, 1'b1, ST_TRAP,   ILL,             2'd0, 2'd0, 3'd0, 2'd0);

    // Reset state: all strobes low even though FETCH would otherwise read
    reset_n = 1'b0; opcode = OP_ADD; mode = 2'b00;
    cmp_gt = 1'b0; cmp_lt = 1'b0; cmp_eq = 1'b0; mem_ready = 1'b1;
    #3;
    check("reset_state", act, exp_of(ST_FETCH, NONE, 2'd0, 2'd0, 3'd0, 2'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].opcode;
      mode   = vecs[i].mode;
      {cmp_gt, cmp_lt, cmp_eq} = vecs[i].flags;
      mem_ready = vecs[i].mem_ready;
      #2;
      check(vecs[i].name, act, vecs[i].expected);
      tick();
    end

    // LW with mode 10 traps at DECODE
    do_reset();
    opcode = OP_LW; mode = 2'b10; mem_ready = 1'b1;
    tick();
    tick();
    check("lw_mode10_trap", act, exp_of(ST_TRAP, ILL, 2'd0, 2'd0, 3'd0, 2'd0));

    // Reset asserted between edges in MEM drops the request immediately
    do_reset();
    opcode = OP_LW; mode = 2'b00; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    check("mid_mem", act, exp_of(ST_MEM, MRD, 2'd0, 2'd0, 3'd0, 2'd1));
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", act, exp_of(ST_FETCH, NONE, 2'd0, 2'd0, 3'd0, 2'd0));
    do_reset();

    // Timeout counter restarts on entry to each wait state: 10 waits in FETCH
    // followed by 15 waits in MEM must not trap
    opcode = OP_LW; mode = 2'b01; mem_ready = 1'b0;
    repeat (10) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    repeat (15) tick();
    check("mem_wait15", act, exp_of(ST_MEM, MRD, 2'd0, 2'd0, 3'd0, 2'd1));
    mem_ready = 1'b1;
    #1;
    check("mem_late_ready", act, exp_of(ST_MEM, MRD|RGW|BWB, 2'd0, 2'd1, 3'd0, 2'd1));
    tick();
    mem_ready = 1'b0;
    #1;
    check("no_timeout", act, exp_of(ST_FETCH, MRD, 2'd0, 2'd0, 3'd0, 2'd0));

    // mem_ready stuck low in FETCH: TRAP after exactly 16 cycles, never ir_write
    do_reset();
    opcode = OP_ADD; mode = 2'b00; mem_ready = 1'b0;
    ir_seen = 1'b0;
    #1;
    ir_seen = ir_seen | ir_write;
    repeat (15) begin
      tick();
      ir_seen = ir_seen | ir_write;
    end
    check("fetch_wait15", act, exp_of(ST_FETCH, MRD, 2'd0, 2'd0, 3'd0, 2'd0));
    tick();
    check("fetch_timeout", act, exp_of(ST_TRAP, ILL, 2'd0, 2'd0, 3'd0, 2'd0));
    mem_ready = 1'b1;
    #1;
    ir_seen = ir_seen | ir_write;
    tick();
    ir_seen = ir_seen | ir_write;
    check("timeout_sticky", act, exp_of(ST_TRAP, ILL, 2'd0, 2'd0, 3'd0, 2'd0));
    check("no_ir_write", {22'd0, ir_seen}, 23'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
